// File: rtl/nf_pkg.sv
// Shared types and helpers for the NOR flash arbiter.
// State encoding, port IDs, counter sizing and byte-lane steering.
package nf_pkg;

    typedef enum logic [2:0] {
        RST,
        IDLE,
        ACCESS,
        DONE,
        REC
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic int cnt_width(
        input int w,
        input int r,
        input int p
    );
        int m;
        m = w;
        if (r > m) m = r;
        if (p > m) m = p;
        return $clog2(m + 1);
    endfunction

    // Byte reads pick the lane selected by the byte address LSB.
    function automatic logic [15:0] steer(
        input logic        byt,
        input logic        lo,
        input logic [15:0] d
    );
        logic [15:0] r;
        r = d;
        if (byt) begin
            r = lo ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
// last_grant records the most recently granted port.
module rr_arb2
    import nf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       last_grant
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
        end else if (grant_en && |req) begin
            last_grant <= gnt[PORT_B];
        end
    end

endmodule

// File: rtl/nf_arbiter.sv
// Two-port read-only NOR flash arbiter and access sequencer.
// Drives the flash pins with programmable wait and recovery cycles.
module nf_arbiter
    import nf_pkg::*;
#(
    parameter int WAIT_CYC = 5,
    parameter int RECOVER  = 1,
    parameter int RP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [19:0] a_addr,
    input  logic        a_byte,
    output logic [15:0] a_data,
    output logic        a_rdy,
    input  logic        b_req,
    input  logic [19:0] b_addr,
    output logic [15:0] b_data,
    output logic        b_rdy,
    input  logic [15:0] nf_d,
    output logic [20:0] nf_a,
    output logic        nf_ce_n,
    output logic        nf_oe_n,
    output logic        nf_we_n,
    output logic        nf_byte_n,
    output logic        nf_rp_n
);

    localparam int CW = cnt_width(WAIT_CYC, RECOVER, RP_CYC);
    localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] RP_LD   = CW'(RP_CYC - 1);
    localparam logic [CW-1:0] REC_LD  =
        CW'((RECOVER > 0) ? RECOVER - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    gnt;
    logic          last_grant;
    logic          lat_byte;
    logic          lat_lo;
    logic [15:0]   rd_val;

    assign nf_we_n   = 1'b1;
    assign nf_byte_n = 1'b1;
    assign rd_val    = steer(lat_byte, lat_lo, nf_d);

    // last_grant doubles as the port owning the current access.
    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({b_req, a_req}),
        .grant_en   (state == IDLE),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST;
            cnt      <= RP_LD;
            nf_a     <= '0;
            nf_ce_n  <= 1'b1;
            nf_oe_n  <= 1'b1;
            nf_rp_n  <= 1'b0;
            a_data   <= '0;
            b_data   <= '0;
            a_rdy    <= 1'b0;
            b_rdy    <= 1'b0;
            lat_byte <= 1'b0;
            lat_lo   <= 1'b0;
        end else begin
            a_rdy <= 1'b0;
            b_rdy <= 1'b0;
            unique case (state)
                RST: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        nf_rp_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (|gnt) begin
                        state    <= ACCESS;
                        cnt      <= WAIT_LD;
                        nf_ce_n  <= 1'b0;
                        nf_oe_n  <= 1'b0;
                        lat_byte <= gnt[PORT_A] & a_byte;
                        lat_lo   <= a_addr[0];
                        nf_a     <= gnt[PORT_B] ?
                                    {2'b00, b_addr[19:1]} :
                                    {2'b00, a_addr[19:1]};
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state   <= DONE;
                        nf_ce_n <= 1'b1;
                        nf_oe_n <= 1'b1;
                        if (last_grant) b_data <= rd_val;
                        else            a_data <= rd_val;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (last_grant) b_rdy <= 1'b1;
                    else            a_rdy <= 1'b1;
                    if (RECOVER > 0) begin
                        state <= REC;
                        cnt   <= REC_LD;
                    end else begin
                        state <= IDLE;
                    end
                end
                REC: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= RST;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_arbiter.sv
// Scoreboard bench for nf_arbiter: stimulus pushes expected reads,
// a negedge monitor pops and checks them on every rdy pulse.
module tb_nf_arbiter;

    localparam int W  = 5;
    localparam int R  = 1;
    localparam int RP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_byte, a_rdy;
    logic [19:0] a_addr, b_addr;
    logic [15:0] a_data, b_data, nf_d;
    logic        b_req, b_rdy;
    logic [20:0] nf_a;
    logic        nf_ce_n, nf_oe_n, nf_we_n, nf_byte_n, nf_rp_n;

    logic [15:0] flash_val;
    logic        pat_mode;

    assign nf_d = pat_mode ? (nf_a[15:0] ^ 16'hA5C3) : flash_val;

    always #5 clk = ~clk;

    nf_arbiter #(
        .WAIT_CYC (W),
        .RECOVER  (R),
        .RP_CYC   (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_byte    (a_byte),
        .a_data    (a_data),
        .a_rdy     (a_rdy),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_rdy     (b_rdy),
        .nf_d      (nf_d),
        .nf_a      (nf_a),
        .nf_ce_n   (nf_ce_n),
        .nf_oe_n   (nf_oe_n),
        .nf_we_n   (nf_we_n),
        .nf_byte_n (nf_byte_n),
        .nf_rp_n   (nf_rp_n)
    );

    typedef struct {
        bit          port;
        logic [15:0] data;
        logic [20:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [20:0] glog[$];
    int          gcyc[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          grant_cyc = -100;
    int          grants = 0;
    logic        prev_ce = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit p, input logic [15:0] d,
                            input logic [20:0] a);
        exp_t x;
        x.port = p;
        x.data = d;
        x.addr = a;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        if (prev_ce === 1'b1 && nf_ce_n === 1'b0) begin
            grant_cyc = cyc;
            grants++;
            glog.push_back(nf_a);
            gcyc.push_back(cyc);
        end
        prev_ce = nf_ce_n;
        if (a_rdy === 1'b1 || b_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rdy", {30'd0, a_rdy, b_rdy}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rdy_onehot", a_rdy & b_rdy, 0);
                chk("rdy_port", b_rdy, e.port);
                chk("rdy_data", b_rdy ? b_data : a_data, e.data);
                chk("rdy_addr", nf_a, e.addr);
                chk("rdy_latency", cyc - grant_cyc, W + 1);
            end
        end
    end

    task automatic wait_rdy(input bit p, input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if ((p ? b_rdy : a_rdy) === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: rdy got 0 expected 1", name);
        end
    endtask

    task automatic wait_grant(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (nf_ce_n === 1'b0) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: ce_n got 1 expected 0", name);
        end
    endtask

    task automatic a_read(input logic [19:0] addr, input bit byt,
                          input logic [15:0] fv,
                          input logic [15:0] exp,
                          input logic [20:0] ea, input string name);
        pat_mode  = 1'b0;
        flash_val = fv;
        push_exp(1'b0, exp, ea);
        a_addr = addr;
        a_byte = byt;
        a_req  = 1'b1;
        wait_rdy(1'b0, name);
        a_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rp_window(input int n, input string name);
        int lo = 0;
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (nf_rp_n === 1'b0) lo++;
            if (nf_ce_n !== 1'b1 || nf_oe_n !== 1'b1) bad++;
            if (a_rdy !== 1'b0 || b_rdy !== 1'b0) bad++;
        end
        chk({name, "_rp_low"}, lo, RP);
        chk({name, "_ctrl"}, bad, 0);
        chk({name, "_rp_high"}, nf_rp_n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        int g0;
        rst_n     = 1'b0;
        a_req     = 1'b0;
        b_req     = 1'b0;
        a_addr    = '0;
        b_addr    = '0;
        a_byte    = 1'b0;
        flash_val = '0;
        pat_mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nf_a", nf_a, 0);
        chk("rst_ce_n", nf_ce_n, 1);
        chk("rst_oe_n", nf_oe_n, 1);
        chk("rst_we_n", nf_we_n, 1);
        chk("rst_byte_n", nf_byte_n, 1);
        chk("rst_rp_n", nf_rp_n, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_rdy", {a_rdy, b_rdy}, 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rp_window(12, "release");

        // Simultaneous held requests straight after reset.
        pat_mode = 1'b1;
        a_addr   = 20'h00200;
        b_addr   = 20'h00401;
        push_exp(1'b0, 16'hA4C3, 21'h000100);
        push_exp(1'b1, 16'hA7C3, 21'h000200);
        push_exp(1'b0, 16'hA4C3, 21'h000100);
        push_exp(1'b1, 16'hA7C3, 21'h000200);
        glog.delete();
        gcyc.delete();
        @(posedge clk);
        #1;
        a_req = 1'b1;
        b_req = 1'b1;
        seen  = 0;
        for (int i = 0; i < 200 && seen < 4; i++) begin
            @(posedge clk);
            #1;
            if (a_rdy === 1'b1 || b_rdy === 1'b1) seen++;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("held_rdy_count", seen, 4);
        repeat (6) @(posedge clk);
        #1;
        chk("held_grants", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("gseq0", glog[0], 21'h000100);
            chk("gseq1", glog[1], 21'h000200);
            chk("gseq2", glog[2], 21'h000100);
            chk("gseq3", glog[3], 21'h000200);
            chk("grant_period", gcyc[1] - gcyc[0], W + 2 + R);
        end

        a_read(20'h00102, 1'b0, 16'hBEEF, 16'hBEEF, 21'h000081,
               "word_read");
        a_read(20'h00103, 1'b1, 16'h12AB, 16'h0012, 21'h000081,
               "byte_hi");
        a_read(20'h00102, 1'b1, 16'h12AB, 16'h00AB, 21'h000081,
               "byte_lo");
        a_read(20'h00103, 1'b0, 16'h12AB, 16'h12AB, 21'h000081,
               "word_odd");
        chk("b_data_hold", b_data, 16'hA7C3);

        // Port B drops its request mid-access.
        pat_mode = 1'b1;
        b_addr   = 20'h0ABCD;
        push_exp(1'b1, 16'hF025, 21'h055E6);
        b_req = 1'b1;
        wait_grant("b_grant");
        repeat (2) @(posedge clk);
        #1;
        b_req = 1'b0;
        g0 = grants;
        wait_rdy(1'b1, "b_drop_rdy");
        repeat (8) @(posedge clk);
        #1;
        chk("no_new_access", grants, g0);
        chk("a_data_hold", a_data, 16'h12AB);

        // Reset pulse in the middle of an access.
        pat_mode  = 1'b0;
        flash_val = 16'h5A5A;
        a_addr    = 20'h00010;
        a_byte    = 1'b0;
        a_req     = 1'b1;
        wait_grant("mid_grant");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_ce_n", nf_ce_n, 1);
        chk("mid_oe_n", nf_oe_n, 1);
        chk("mid_rp_n", nf_rp_n, 0);
        chk("mid_a_data", a_data, 0);
        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 16'h5A5A, 21'h000008);
        rst_n = 1'b1;
        rp_window(5, "rerun");
        wait_rdy(1'b0, "retry_rdy");
        a_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
